counter_rr_scheduler: RTL

Shares one free-running counter datapath between NUM_REQ requesters using round-robin arbitration. Each grant runs a burst: clear the counter, then BURST increments with wrap-around, then report completion. Sits in the benchmark design list as the sequencing layer above the simple counter. It produces deterministic multi-signal waveforms (one-hot grants, wrapping counts, FSM state) for the FST writer and reader benchmarks.

---
 rtl/counter_rr_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler that lends one shared counter to NUM_REQ requesters.
// Each grant clears the counter and then counts BURST beats, unless it is stalled or aborted.
module counter_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int BURST   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       stall,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [CNT_W-1:0]           cnt_val,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       aborted
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [7:0]          beat_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     gnt_idx_reg;
    logic                done_reg;
    logic [ID_W-1:0]     done_id_reg;
    logic                aborted_reg;
    logic                busy_reg;

    logic                winner_valid;
    logic [ID_W-1:0]     winner_idx;
    logic [ID_W:0]       cand;
    logic [NUM_REQ-1:0]  winner_onehot;
    logic                granted_req;
    logic [ID_W-1:0]     rr_ptr_next;

    // Walk offsets from the highest down so the offset closest to rr_ptr wins.
    always_comb begin
        winner_valid = 1'b0;
        winner_idx   = '0;
        cand         = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (req[cand[ID_W-1:0]]) begin
                winner_valid = 1'b1;
                winner_idx   = cand[ID_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner_idx == ID_W'(gi));
        end
    endgenerate

    assign granted_req = req[gnt_idx_reg];
    assign rr_ptr_next = (gnt_idx_reg == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_reg + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            cnt_reg     <= '0;
            beat_reg    <= '0;
            rr_ptr_reg  <= '0;
            gnt_idx_reg <= '0;
            done_reg    <= 1'b0;
            done_id_reg <= '0;
            aborted_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (winner_valid) begin
                        state_reg   <= RUN;
                        busy_reg    <= 1'b1;
                        grant_reg   <= winner_onehot;
                        gnt_idx_reg <= winner_idx;
                        cnt_reg     <= '0;
                        beat_reg    <= '0;
                    end
                end
                RUN: begin
                    // A dropped request outranks stall; the count stays where it stopped.
                    if (!granted_req) begin
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                        done_id_reg <= gnt_idx_reg;
                        aborted_reg <= 1'b1;
                    end else if (!stall) begin
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                        beat_reg <= beat_reg + 8'd1;
                        if (beat_reg == 8'(BURST - 1)) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            done_id_reg <= gnt_idx_reg;
                            aborted_reg <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    grant_reg  <= '0;
                    done_reg   <= 1'b0;
                    rr_ptr_reg <= rr_ptr_next;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant   = grant_reg;
    assign busy    = busy_reg;
    assign cnt_val = cnt_reg;
    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign aborted = aborted_reg;

endmodule
